// File: rtl/inst_fetch_unit_if.sv
// Bundle of load-control, source-BRAM and fetch signals for inst_fetch_unit.
// The slave side is the fetch unit; the master side is the core/loader driving it.
interface inst_fetch_unit_if #(
    parameter int ADDR_W  = 14,
    parameter int FETCH_W = 2
);
    logic [2:0]           mode;
    logic [ADDR_W:0]      load_len;
    logic [ADDR_W-1:0]    src_addr;
    logic                 src_en;
    logic [31:0]          src_data;
    logic                 load_busy;
    logic                 done;
    logic [ADDR_W:0]      loaded_count;
    logic [31:0]          pc;
    logic                 fetch_req;
    logic                 fetch_valid;
    logic [32*FETCH_W-1:0] inst;
    logic [FETCH_W-1:0]   inst_mask;
    logic                 fetch_fault;

    modport master (
        output mode, load_len, src_data, pc, fetch_req,
        input  src_addr, src_en, load_busy, done, loaded_count,
               fetch_valid, inst, inst_mask, fetch_fault
    );

    modport slave (
        input  mode, load_len, src_data, pc, fetch_req,
        output src_addr, src_en, load_busy, done, loaded_count,
               fetch_valid, inst, inst_mask, fetch_fault
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Copies a program from a source BRAM into a local store (LOAD), then serves FETCH_W-wide
// registered fetches one cycle after each accepted request (EXEC), with per-slot mask and fault.
module inst_fetch_unit #(
    parameter int ADDR_W   = 14,
    parameter int FETCH_W  = 2,
    parameter int BRAM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    inst_fetch_unit_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [2:0]    MODE_LOAD = 3'd1;
    localparam logic [2:0]    MODE_EXEC = 3'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]       len_q, len_eff, len_m1, cnt_q;
    logic [ADDR_W-1:0]   src_addr_q;
    logic                src_en_q, load_busy_q, done_q, mode_was_load;
    logic [BRAM_LAT-1:0] pipe_vld;
    logic [ADDR_W-1:0]   pipe_addr [BRAM_LAT];
    logic [31:0]         store [DEPTH];

    logic is_load, is_exec, loading, abort, last_issue, wr_en, final_wr, start;

    assign is_load    = bus.mode == MODE_LOAD;
    assign is_exec    = bus.mode == MODE_EXEC;
    assign len_eff    = (bus.load_len == '0 || bus.load_len > DEPTH_C) ? DEPTH_C : bus.load_len;
    assign len_m1     = len_q - CW'(1);
    assign loading    = state == ISSUE || state == DRAIN;
    assign abort      = loading && !is_load;
    assign last_issue = src_addr_q == len_m1[ADDR_W-1:0];
    assign wr_en      = loading && is_load && pipe_vld[BRAM_LAT-1];
    assign final_wr   = wr_en && pipe_addr[BRAM_LAT-1] == len_m1[ADDR_W-1:0];
    assign start      = (state == IDLE || state == DONE) && state_nxt == ISSUE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_load) state_nxt = ISSUE;
            ISSUE:   if (!is_load) state_nxt = IDLE; else if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (!is_load) state_nxt = IDLE; else if (final_wr) state_nxt = DONE;
            DONE:    if (is_load && !mode_was_load) state_nxt = ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            len_q         <= '0;
            cnt_q         <= '0;
            src_addr_q    <= '0;
            src_en_q      <= 1'b0;
            load_busy_q   <= 1'b0;
            done_q        <= 1'b0;
            mode_was_load <= 1'b0;
            pipe_vld      <= '0;
        end else begin
            state         <= state_nxt;
            mode_was_load <= is_load;
            if (abort) begin
                // Returns still in the pipe belong to the abandoned load.
                pipe_vld <= '0;
            end else begin
                pipe_vld[0] <= src_en_q;
                for (int k = 1; k < BRAM_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
            end
            if (wr_en) cnt_q <= cnt_q + CW'(1);

            if (start) begin
                len_q       <= len_eff;
                src_en_q    <= 1'b1;
                src_addr_q  <= '0;
                cnt_q       <= '0;
                load_busy_q <= 1'b1;
                done_q      <= 1'b0;
            end else if (abort) begin
                src_en_q    <= 1'b0;
                load_busy_q <= 1'b0;
                done_q      <= 1'b0;
                cnt_q       <= '0;
            end else if (state == ISSUE) begin
                if (last_issue) src_en_q <= 1'b0;
                else            src_addr_q <= src_addr_q + 1'b1;
            end else if (final_wr) begin
                done_q      <= 1'b1;
                load_busy_q <= 1'b0;
                cnt_q       <= len_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_addr[0] <= src_addr_q;
        for (int k = 1; k < BRAM_LAT; k++) pipe_addr[k] <= pipe_addr[k-1];
        if (wr_en) store[pipe_addr[BRAM_LAT-1]] <= bus.src_data;
    end

    logic [CW-1:0]         slot_idx [FETCH_W];
    logic [FETCH_W-1:0]    slot_ok;
    logic [32*FETCH_W-1:0] slot_dat;
    logic                  pc_aligned, pc_in_range, accept;
    logic                  fetch_valid_q, fetch_fault_q;
    logic [32*FETCH_W-1:0] inst_q;
    logic [FETCH_W-1:0]    mask_q;

    assign pc_aligned  = bus.pc[1:0] == 2'b00;
    assign pc_in_range = bus.pc[31:ADDR_W+2] == '0;
    assign accept      = state == DONE && is_exec && bus.fetch_req;

    // Slot index is one bit wider than the store address so reads past the end never wrap.
    always_comb begin
        slot_ok  = '0;
        slot_dat = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            slot_idx[i] = {1'b0, bus.pc[ADDR_W+1:2]} + CW'(i);
            slot_ok[i]  = pc_in_range && pc_aligned && (slot_idx[i] < cnt_q);
            if (slot_ok[i]) slot_dat[32*i +: 32] = store[slot_idx[i][ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            inst_q        <= '0;
            mask_q        <= '0;
        end else begin
            fetch_valid_q <= accept;
            if (accept) begin
                inst_q        <= slot_dat;
                mask_q        <= slot_ok;
                fetch_fault_q <= !pc_aligned;
            end
        end
    end

    assign bus.src_addr     = src_addr_q;
    assign bus.src_en       = src_en_q;
    assign bus.load_busy    = load_busy_q;
    assign bus.done         = done_q;
    assign bus.loaded_count = cnt_q;
    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.inst         = inst_q;
    assign bus.inst_mask    = mask_q;
    assign bus.fetch_fault  = fetch_fault_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: load timing, fetch masks, faults, abort and async reset.
module tb_inst_fetch_unit;
    localparam int AW  = 4;
    localparam int FW  = 2;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_unit_if #(.ADDR_W(AW), .FETCH_W(FW)) bus ();
    inst_fetch_unit #(.ADDR_W(AW), .FETCH_W(FW), .BRAM_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Two-register source BRAM: address in cycle c, data on src_data in cycle c+2.
    logic [31:0] src_mem [16];
    logic [31:0] r0, r1;
    always @(posedge clk) begin
        r0 <= src_mem[bus.src_addr];
        r1 <= r0;
    end
    assign bus.src_data = r1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mode = 3'd0; bus.load_len = '0; bus.pc = '0; bus.fetch_req = 1'b0;
        #2;
        n_cmp++;
        if ({bus.src_en, bus.src_addr, bus.load_busy, bus.done, bus.loaded_count,
             bus.fetch_valid, bus.inst, bus.inst_mask, bus.fetch_fault} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got nonzero (inst=%h cnt=%0d) want all 0", bus.inst, bus.loaded_count);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.src_en !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_idle: got en=%b done=%b want 0 0", bus.src_en, bus.done);
        end
    endtask

    // Runs one load from a non-LOAD mode and checks the cycle-by-cycle schedule.
    task automatic test_load_seq(input int len, input int eff, input logic [31:0] pat, input string tag);
        int cnt_exp;
        for (int j = 0; j < 16; j++) src_mem[j] = pat + 32'(j);
        bus.mode = 3'd0; bus.fetch_req = 1'b0;
        tick();
        bus.load_len = 5'(len); bus.mode = 3'd1;
        tick();
        for (int n = 1; n <= eff + LAT + 1; n++) begin
            cnt_exp = (n - 1 - LAT < 0) ? 0 : n - 1 - LAT;
            n_cmp++;
            if (bus.src_en !== (n <= eff)) begin
                n_bad++; $display("FAIL %s src_en cyc%0d: got %b want %b", tag, n, bus.src_en, n <= eff);
            end
            if (n <= eff) begin
                n_cmp++;
                if (bus.src_addr !== 4'(n - 1)) begin
                    n_bad++; $display("FAIL %s src_addr cyc%0d: got %0d want %0d", tag, n, bus.src_addr, n - 1);
                end
            end
            n_cmp++;
            if (bus.load_busy !== (n < eff + LAT + 1)) begin
                n_bad++; $display("FAIL %s load_busy cyc%0d: got %b want %b", tag, n, bus.load_busy, n < eff + LAT + 1);
            end
            n_cmp++;
            if (bus.done !== (n == eff + LAT + 1)) begin
                n_bad++; $display("FAIL %s done cyc%0d: got %b want %b", tag, n, bus.done, n == eff + LAT + 1);
            end
            n_cmp++;
            if (bus.loaded_count !== 5'(cnt_exp)) begin
                n_bad++; $display("FAIL %s loaded_count cyc%0d: got %0d want %0d", tag, n, bus.loaded_count, cnt_exp);
            end
            if (n < eff + LAT + 1) tick();
        end
    endtask

    task automatic test_fetch();
        bus.mode = 3'd2; bus.pc = 32'h4; bus.fetch_req = 1'b1;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b1 || bus.inst !== 64'h000000A2_000000A1 || bus.inst_mask !== 2'b11 || bus.fetch_fault !== 1'b0) begin
            n_bad++; $display("FAIL fetch_pc4: got v=%b inst=%h m=%b f=%b want 1 a2_a1 11 0", bus.fetch_valid, bus.inst, bus.inst_mask, bus.fetch_fault);
        end
        bus.fetch_req = 1'b0;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b0 || bus.inst !== 64'h000000A2_000000A1 || bus.inst_mask !== 2'b11) begin
            n_bad++; $display("FAIL fetch_hold: got v=%b inst=%h m=%b want 0 a2_a1 11", bus.fetch_valid, bus.inst, bus.inst_mask);
        end
        bus.pc = 32'hC; bus.fetch_req = 1'b1;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b1 || bus.inst !== 64'h00000000_000000A3 || bus.inst_mask !== 2'b01) begin
            n_bad++; $display("FAIL fetch_pcC: got v=%b inst=%h m=%b want 1 0_a3 01", bus.fetch_valid, bus.inst, bus.inst_mask);
        end
        bus.pc = 32'h0;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b1 || bus.inst !== 64'h000000A1_000000A0 || bus.inst_mask !== 2'b11) begin
            n_bad++; $display("FAIL b2b_first: got v=%b inst=%h m=%b want 1 a1_a0 11", bus.fetch_valid, bus.inst, bus.inst_mask);
        end
        bus.pc = 32'h8;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b1 || bus.inst !== 64'h000000A3_000000A2 || bus.inst_mask !== 2'b11) begin
            n_bad++; $display("FAIL b2b_second: got v=%b inst=%h m=%b want 1 a3_a2 11", bus.fetch_valid, bus.inst, bus.inst_mask);
        end
        bus.fetch_req = 1'b0;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_end: got v=%b want 0", bus.fetch_valid);
        end
    endtask

    task automatic test_full_depth();
        test_load_seq(20, 16, 32'h180, "len20");
        test_load_seq(0, 16, 32'h100, "len0");
        tick(); tick();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.src_en !== 1'b0 || bus.load_busy !== 1'b0 || bus.loaded_count !== 5'd16) begin
            n_bad++; $display("FAIL hold_load_done: got d=%b en=%b b=%b cnt=%0d want 1 0 0 16", bus.done, bus.src_en, bus.load_busy, bus.loaded_count);
        end
        bus.mode = 3'd2; bus.pc = 32'h3C; bus.fetch_req = 1'b1;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b1 || bus.inst !== 64'h00000000_0000010F || bus.inst_mask !== 2'b01) begin
            n_bad++; $display("FAIL fetch_last: got v=%b inst=%h m=%b want 1 0_10f 01", bus.fetch_valid, bus.inst, bus.inst_mask);
        end
        bus.pc = 32'h40;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b1 || bus.inst !== 64'h0 || bus.inst_mask !== 2'b00 || bus.fetch_fault !== 1'b0) begin
            n_bad++; $display("FAIL fetch_oob: got v=%b inst=%h m=%b f=%b want 1 0 00 0", bus.fetch_valid, bus.inst, bus.inst_mask, bus.fetch_fault);
        end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_fault();
        bus.mode = 3'd2; bus.pc = 32'h6; bus.fetch_req = 1'b1;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_fault !== 1'b1 || bus.inst_mask !== 2'b00 || bus.inst !== 64'h0) begin
            n_bad++; $display("FAIL misaligned: got v=%b f=%b m=%b inst=%h want 1 1 00 0", bus.fetch_valid, bus.fetch_fault, bus.inst_mask, bus.inst);
        end
        bus.pc = 32'h0;
        tick();
        n_cmp++;
        if (bus.fetch_fault !== 1'b0 || bus.inst_mask !== 2'b11 || bus.inst !== 64'h00000101_00000100) begin
            n_bad++; $display("FAIL fault_clear: got f=%b m=%b inst=%h want 0 11 101_100", bus.fetch_fault, bus.inst_mask, bus.inst);
        end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        for (int j = 0; j < 16; j++) src_mem[j] = 32'h200 + 32'(j);
        bus.mode = 3'd0;
        tick();
        bus.mode = 3'd1; bus.load_len = 5'd4; bus.pc = 32'h0; bus.fetch_req = 1'b1;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b0 || bus.src_en !== 1'b1 || bus.src_addr !== 4'd0 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL issue_c1: got v=%b en=%b a=%0d d=%b want 0 1 0 0", bus.fetch_valid, bus.src_en, bus.src_addr, bus.done);
        end
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b0 || bus.src_addr !== 4'd1) begin
            n_bad++; $display("FAIL issue_c2: got v=%b a=%0d want 0 1", bus.fetch_valid, bus.src_addr);
        end
        tick();
        bus.mode = 3'd0;
        tick();
        n_cmp++;
        if ({bus.src_en, bus.load_busy, bus.done, bus.loaded_count, bus.fetch_valid} !== '0) begin
            n_bad++; $display("FAIL abort: got en=%b b=%b d=%b cnt=%0d v=%b want all 0", bus.src_en, bus.load_busy, bus.done, bus.loaded_count, bus.fetch_valid);
        end
        bus.mode = 3'd2;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b0) begin
            n_bad++; $display("FAIL fetch_in_idle: got v=%b want 0", bus.fetch_valid);
        end
        test_load_seq(4, 4, 32'h200, "reload");
        bus.mode = 3'd2; bus.pc = 32'h0; bus.fetch_req = 1'b1;
        tick();
        n_cmp++;
        if (bus.inst !== 64'h00000201_00000200 || bus.inst_mask !== 2'b11) begin
            n_bad++; $display("FAIL reload_fetch: got inst=%h m=%b want 201_200 11", bus.inst, bus.inst_mask);
        end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        for (int j = 0; j < 16; j++) src_mem[j] = 32'h300 + 32'(j);
        bus.mode = 3'd0;
        tick();
        bus.mode = 3'd1; bus.load_len = 5'd4;
        tick();
        for (int n = 0; n < 4; n++) tick();
        n_cmp++;
        if (bus.load_busy !== 1'b1 || bus.src_en !== 1'b0) begin
            n_bad++; $display("FAIL pre_rst_drain: got b=%b en=%b want 1 0", bus.load_busy, bus.src_en);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.src_en, bus.src_addr, bus.load_busy, bus.done, bus.loaded_count,
             bus.fetch_valid, bus.inst, bus.inst_mask, bus.fetch_fault} !== '0) begin
            n_bad++; $display("FAIL async_reset: got b=%b cnt=%0d inst=%h want all 0", bus.load_busy, bus.loaded_count, bus.inst);
        end
        bus.mode = 3'd0;
        tick();
        rst = 1'b0;
        test_load_seq(4, 4, 32'h300, "after_rst");
        bus.mode = 3'd2; bus.pc = 32'h8; bus.fetch_req = 1'b1;
        tick();
        n_cmp++;
        if (bus.fetch_valid !== 1'b1 || bus.inst !== 64'h00000303_00000302 || bus.inst_mask !== 2'b11) begin
            n_bad++; $display("FAIL post_rst_fetch: got v=%b inst=%h m=%b want 1 303_302 11", bus.fetch_valid, bus.inst, bus.inst_mask);
        end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_seq(4, 4, 32'hA0, "load4");
        test_fetch();
        test_full_depth();
        test_fault();
        test_abort();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
